// File: rtl/led_bank_if.sv
// Purpose : CPU IO bus bundle between the IO address decoder and the LED bank.
// Latency : none of its own; only carries the write strobe and the readback path.
// Backpress: none; every write strobe is accepted on the falling edge it is sampled.
//
// Signals:
//   wr_en   - write strobe from the IO decoder
//   addr    - register select (3 bits)
//   wr_data - CPU write data
//   rd_data - combinational readback of the selected register
interface led_bank_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  wr_en;
    logic [2:0]            addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;

    // CPU / decoder side
    modport master (
        output wr_en,
        output addr,
        output wr_data,
        input  rd_data
    );

    // LED bank side
    modport slave (
        input  wr_en,
        input  addr,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/led_bank_ctrl.sv
// Purpose : memory-mapped LED bank with SET/CLR/TOGGLE writes, per-LED blink mask and blink divider.
// Latency : writes visible on led_out right after the updating falling edge; readback is combinational.
// Backpress: none; every wr_en strobe is applied on the falling edge it is sampled.
//
// Ports:
//   clk     - system clock, all state updates on the falling edge
//   rst     - asynchronous active-low reset
//   bus     - IO bus (wr_en, addr, wr_data in; rd_data out)
//   led_out - LED pin drive, active-high
module led_bank_ctrl #(
    parameter int                    LED_WIDTH   = 16,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    CNT_WIDTH   = 24,
    parameter logic [CNT_WIDTH-1:0]  DEFAULT_DIV = CNT_WIDTH'(5_000_000)
) (
    input  logic                 clk,
    input  logic                 rst,
    led_bank_if.slave            bus,
    output logic [LED_WIDTH-1:0] led_out
);

    typedef enum logic [2:0] {
        REG_DATA   = 3'd0,
        REG_SET    = 3'd1,
        REG_CLR    = 3'd2,
        REG_TOGGLE = 3'd3,
        REG_BLINK  = 3'd4,
        REG_DIV    = 3'd5,
        REG_RSV6   = 3'd6,
        REG_RSV7   = 3'd7
    } reg_addr_e;

    // State
    logic [LED_WIDTH-1:0] led_reg;
    logic [LED_WIDTH-1:0] blink_mask;
    logic [CNT_WIDTH-1:0] div_reg;
    logic [CNT_WIDTH-1:0] blink_cnt;
    logic                 phase;

    // Next-state
    logic [LED_WIDTH-1:0] led_nxt;
    logic [LED_WIDTH-1:0] mask_nxt;
    logic [CNT_WIDTH-1:0] div_nxt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 phase_nxt;

    logic [LED_WIDTH-1:0] wr_d;
    logic [CNT_WIDTH-1:0] wr_div;
    reg_addr_e            sel;

    assign wr_d   = bus.wr_data[LED_WIDTH-1:0];
    assign wr_div = bus.wr_data[CNT_WIDTH-1:0];
    assign sel    = reg_addr_e'(bus.addr);

    // Upper write-data bits are architecturally ignored.
    logic unused_wr_data;
    assign unused_wr_data = &{1'b0, bus.wr_data};

    always_comb begin
        led_nxt   = led_reg;
        mask_nxt  = blink_mask;
        div_nxt   = div_reg;
        cnt_nxt   = blink_cnt;
        phase_nxt = phase;

        // Blink engine. A divider of zero parks the phase high so that
        // blinking LEDs read as steadily lit instead of freezing dark.
        if (div_reg == '0) begin
            cnt_nxt   = '0;
            phase_nxt = 1'b1;
        end else if (blink_cnt == div_reg) begin
            cnt_nxt   = '0;
            phase_nxt = ~phase;
        end else begin
            cnt_nxt   = blink_cnt + CNT_WIDTH'(1);
        end

        // Register writes. The DIV case is evaluated after the engine so a
        // divider write restarts the counter/phase even on a wrap edge.
        if (bus.wr_en) begin
            case (sel)
                REG_DATA:   led_nxt  = wr_d;
                REG_SET:    led_nxt  = led_reg | wr_d;
                REG_CLR:    led_nxt  = led_reg & ~wr_d;
                REG_TOGGLE: led_nxt  = led_reg ^ wr_d;
                REG_BLINK:  mask_nxt = wr_d;
                REG_DIV: begin
                    div_nxt   = wr_div;
                    cnt_nxt   = '0;
                    phase_nxt = 1'b1;
                end
                default: ;  // 6, 7 reserved: writes dropped
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            led_reg    <= '0;
            blink_mask <= '0;
            div_reg    <= DEFAULT_DIV;
            blink_cnt  <= '0;
            phase      <= 1'b1;
        end else begin
            led_reg    <= led_nxt;
            blink_mask <= mask_nxt;
            div_reg    <= div_nxt;
            blink_cnt  <= cnt_nxt;
            phase      <= phase_nxt;
        end
    end

    // Readback: zero-extended, addresses 0-3 all alias the LED register.
    always_comb begin
        bus.rd_data = '0;
        case (sel)
            REG_DATA, REG_SET, REG_CLR, REG_TOGGLE:
                bus.rd_data[LED_WIDTH-1:0] = led_reg;
            REG_BLINK:
                bus.rd_data[LED_WIDTH-1:0] = blink_mask;
            REG_DIV:
                bus.rd_data[CNT_WIDTH-1:0] = div_reg;
            default:
                bus.rd_data = '0;
        endcase
    end

    // Driven from registers only so the pins never glitch on bus activity.
    assign led_out = led_reg & (~blink_mask | {LED_WIDTH{phase}});

endmodule
